// File: rtl/sram_fifo_ctrl_0rw1r1w.sv
// Show-ahead valid/ready FIFO controller in front of a 1W/1R SRAM macro, with a 2-entry prefetch
// buffer. Optional even-parity protection of stored words is enabled by defining FIFO_PARITY_EN.
module sram_fifo_ctrl_0rw1r1w #(
    parameter int unsigned DATA_WIDTH = 22,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned LVL_W      = ADDR_WIDTH + 1,
`ifdef FIFO_PARITY_EN
    localparam int unsigned PW        = DATA_WIDTH - 1
`else
    localparam int unsigned PW        = DATA_WIDTH
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef FIFO_PARITY_EN
    output logic                  parity_err,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PW-1:0]         in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PW-1:0]         out_data,
    output logic [LVL_W-1:0]      level,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      scnt_q, scnt_d;
    logic                  rd_pend_q;
    logic [1:0]            ocnt_q, ocnt_d;
    logic [PW-1:0]         obuf_q [2];
    logic [PW-1:0]         obuf_d [2];

    logic                  not_full;
    logic                  push;
    logic                  pop;
    logic                  rd_go;
    logic [1:0]            cap_idx;

    // State updates use the reset-free terms; reset overrides them in the flops anyway, and the
    // port-visible strobes are additionally gated by rst.
    assign not_full  = (scnt_q < LVL_W'(DEPTH));
    assign push      = in_valid && not_full;
    assign out_valid = (ocnt_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign rd_go     = (scnt_q != '0) &&
                       (({1'b0, ocnt_q} + {2'b00, rd_pend_q}) < (3'd2 + {2'b00, pop}));

    assign in_ready   = !rst && not_full;
    assign sram_csb0  = !(push && !rst);
    assign sram_addr0 = wr_ptr_q;
    assign sram_csb1  = !(rd_go && !rst);
    assign sram_addr1 = rd_ptr_q;

`ifdef FIFO_PARITY_EN
    assign sram_din0 = {^in_data, in_data};
`else
    assign sram_din0 = in_data;
`endif

    assign out_data = obuf_q[0];
    assign level    = scnt_q + LVL_W'(rd_pend_q) + LVL_W'(ocnt_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_go) begin
            rd_ptr_d = (rd_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        scnt_d = scnt_q + LVL_W'(push) - LVL_W'(rd_go);
    end

    // A returning word lands behind whatever survives this cycle's pop, preserving order.
    always_comb begin
        obuf_d  = obuf_q;
        ocnt_d  = ocnt_q + 2'(rd_pend_q) - 2'(pop);
        cap_idx = ocnt_q - 2'(pop);
        if (pop) begin
            obuf_d[0] = obuf_q[1];
        end
        if (rd_pend_q) begin
            if (cap_idx == 2'd0) begin
                obuf_d[0] = sram_dout1[PW-1:0];
            end else begin
                obuf_d[1] = sram_dout1[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            scnt_q    <= '0;
            rd_pend_q <= 1'b0;
            ocnt_q    <= 2'd0;
            obuf_q[0] <= '0;
            obuf_q[1] <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            scnt_q    <= scnt_d;
            rd_pend_q <= rd_go;
            ocnt_q    <= ocnt_d;
            obuf_q    <= obuf_d;
        end
    end

`ifdef FIFO_PARITY_EN
    logic parity_err_q;

    assign parity_err = parity_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else if (rd_pend_q && (^sram_dout1)) begin
            parity_err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl_0rw1r1w.sv
// Directed bench for sram_fifo_ctrl_0rw1r1w with a behavioural 1W/1R SRAM attached.
// Define FIFO_PARITY_EN to build against the parity variant.
module tb_sram_fifo_ctrl_0rw1r1w;

    localparam int DW    = 22;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int LW    = AW + 1;
`ifdef FIFO_PARITY_EN
    localparam int PW    = DW - 1;
`else
    localparam int PW    = DW;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_data;
    logic [LW-1:0] level;
    logic          sram_csb0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic          sram_csb1;
    logic [AW-1:0] sram_addr1;
    logic [DW-1:0] sram_dout1 = '0;
`ifdef FIFO_PARITY_EN
    logic          parity_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    sram_fifo_ctrl_0rw1r1w dut (
        .clk        (clk),
        .rst        (rst),
`ifdef FIFO_PARITY_EN
        .parity_err (parity_err),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .sram_csb0  (sram_csb0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Macro model: capture at posedge, launch read data at the following negedge.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_addr_m = '0;
    logic          rd_fire_m = 1'b0;
    logic          flip_en   = 1'b0;

    always @(posedge clk) begin
        if (!sram_csb0) mem[sram_addr0] <= sram_din0;
        rd_fire_m <= !sram_csb1;
        if (!sram_csb1) rd_addr_m <= sram_addr1;
    end

    always @(negedge clk) begin
        if (rd_fire_m) sram_dout1 <= mem[rd_addr_m] ^ (flip_en ? DW'(8) : DW'(0));
    end

    // Port-side model of pointer sequence and SRAM occupancy.
    int wexp = 0;
    int rexp = 0;
    int mscnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            wexp = 0;
            rexp = 0;
            mscnt = 0;
        end else begin
            if (!sram_csb0) check("wr_addr", 32'(sram_addr0), wexp % DEPTH);
            if (!sram_csb1) begin
                check("rd_addr", 32'(sram_addr1), rexp % DEPTH);
                check("rd_nonempty", 32'(mscnt != 0), 1);
            end
            if (!sram_csb0 && !sram_csb1) check("addr_clash", 32'(sram_addr0 != sram_addr1), 1);
            if (!sram_csb0) wexp++;
            if (!sram_csb1) rexp++;
            mscnt = mscnt + (!sram_csb0 ? 1 : 0) - (!sram_csb1 ? 1 : 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [PW-1:0] sb [$];
    logic [PW-1:0] exp_w;

    initial begin
        int pushed;
        int popped;
        int n;
        int g;

        // Reset state, with a push request held during reset
        in_valid = 1'b1;
        in_data  = PW'(5);
        #12;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_csb0", 32'(sram_csb0), 1);
        check("rst_csb1", 32'(sram_csb1), 1);
        check("rst_level", 32'(level), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        in_valid = 1'b0;
        cyc();
        rst = 1'b0;

        // T1: single push, visible two edges later
        in_valid = 1'b1;
        in_data  = PW'(22'h0ABCDE);
        #1;
        check("t1_csb0", 32'(sram_csb0), 0);
        check("t1_addr0", 32'(sram_addr0), 0);
        check("t1_in_ready", 32'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        #1;
        check("t1_e0_level", 32'(level), 1);
        check("t1_e0_valid", 32'(out_valid), 0);
        check("t1_e0_csb1", 32'(sram_csb1), 0);
        cyc();
        check("t1_e1_level", 32'(level), 1);
        check("t1_e1_valid", 32'(out_valid), 0);
        cyc();
        check("t1_e2_valid", 32'(out_valid), 1);
        check("t1_e2_data", 32'(out_data), 32'h0ABCDE);
        check("t1_e2_level", 32'(level), 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("t1_pop_valid", 32'(out_valid), 0);
        check("t1_pop_level", 32'(level), 0);

        // T2: fill to DEPTH+2, reject extra push, drain in order across pointer wrap
        for (int i = 0; i < 34; i++) begin
            in_valid = 1'b1;
            in_data  = PW'(i);
            #1;
            check("t2_fill_ready", 32'(in_ready), 1);
            cyc();
        end
        in_valid = 1'b0;
        #1;
        check("t2_full_ready", 32'(in_ready), 0);
        check("t2_full_level", 32'(level), 34);
        in_valid = 1'b1;
        in_data  = PW'(99);
        #1;
        check("t2_full_csb0", 32'(sram_csb0), 1);
        cyc();
        in_valid = 1'b0;
        check("t2_full_level2", 32'(level), 34);
        out_ready = 1'b1;
        for (int i = 0; i < 34; i++) begin
            g = 0;
            while (!out_valid && g < 20) begin
                cyc();
                g++;
            end
            check("t2_drain_valid", 32'(out_valid), 1);
            check("t2_drain_data", 32'(out_data), i);
            cyc();
        end
        out_ready = 1'b0;
        check("t2_empty_valid", 32'(out_valid), 0);
        check("t2_empty_level", 32'(level), 0);

        // T3: streaming; steady level is one word in SRAM, one in flight, one buffered
        pushed = 0;
        popped = 0;
        n = 0;
        out_ready = 1'b1;
        while (popped < 100 && n < 400) begin
            in_valid = (pushed < 100);
            in_data  = PW'(32'h100 + pushed);
            if (n >= 3 && pushed < 100) check("t3_level", 32'(level), 3);
            if (n >= 3) check("t3_valid", 32'(out_valid), 1);
            if (in_valid && in_ready) pushed++;
            if (out_valid) begin
                check("t3_data", 32'(out_data), 32'h100 + popped);
                popped++;
            end
            cyc();
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t3_count", popped, 100);

        // T4: random handshakes against a scoreboard
        pushed = 0;
        popped = 0;
        n = 0;
        while (popped < 1000 && n < 20000) begin
            in_valid  = (pushed < 1000) && ($urandom_range(0, 1) == 1);
            in_data   = PW'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                pushed++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() > 0) begin
                    exp_w = sb.pop_front();
                    check("t4_data", 32'(out_data), 32'(exp_w));
                end else begin
                    check("t4_spurious", 32'(out_valid), 0);
                end
                popped++;
            end
            cyc();
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t4_count", popped, 1000);

        // T5: reset with level 10 and a read in flight
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = PW'(32'h200 + i);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        check("t5_level10", 32'(level), 10);
        in_valid  = 1'b1;
        in_data   = PW'(32'h20A);
        out_ready = 1'b1;
        check("t5_head", 32'(out_data), 32'h200);
        cyc();
        out_ready = 1'b0;
        check("t5_level_pend", 32'(level), 10);
        rst = 1'b1;
        #1;
        check("t5_rst_level", 32'(level), 0);
        check("t5_rst_valid", 32'(out_valid), 0);
        check("t5_rst_csb0", 32'(sram_csb0), 1);
        check("t5_rst_csb1", 32'(sram_csb1), 1);
        check("t5_rst_ready", 32'(in_ready), 0);
        cyc();
        check("t5_rst_csb0b", 32'(sram_csb0), 1);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("t5_post_level", 32'(level), 0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = PW'(32'h300 + i);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            g = 0;
            while (!out_valid && g < 20) begin
                cyc();
                g++;
            end
            check("t5_data", 32'(out_data), 32'h300 + i);
            cyc();
        end
        out_ready = 1'b0;
        check("t5_empty_level", 32'(level), 0);

`ifdef FIFO_PARITY_EN
        // T6: corrupt one returning word; flag is sticky, data still delivered
        check("t6_clean", 32'(parity_err), 0);
        flip_en  = 1'b1;
        in_valid = 1'b1;
        in_data  = PW'(32'h1234);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("t6_before_cap", 32'(parity_err), 0);
        cyc();
        flip_en = 1'b0;
        check("t6_err_set", 32'(parity_err), 1);
        check("t6_bad_valid", 32'(out_valid), 1);
        check("t6_bad_data", 32'(out_data), 32'h123C);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = PW'(32'h0555);
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        check("t6_good_data", 32'(out_data), 32'h0555);
        check("t6_err_held", 32'(parity_err), 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_err_clr", 32'(parity_err), 0);
        cyc();
        rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
